// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, complex word type and bit-reverse helper for the FFT datapath
package fft_pkg;

    localparam int FLOAT_LEN = 32;
    localparam int WORD_LEN  = 2 * FLOAT_LEN;

    typedef struct packed {
        logic [FLOAT_LEN-1:0] re;
        logic [FLOAT_LEN-1:0] im;
    } complex_t;

    // Reverse the low `width` bits of value; bits above width come back as 0.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] result;
        int          src;
        int          dst;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                dst = i;
                src = width - 1 - i;
                result[dst[4:0]] = value[src[4:0]];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_sdp_bank.sv
// rtl/ram_sdp_bank.sv - simple dual-port RAM, one write port, one registered read port
module ram_sdp_bank #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port: contents are never reset, only valid once written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: one cycle of latency from address to data.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong bit-reversed to natural order buffer; FFT_REORDER_LAST_EN adds data_out_last and frame_cnt
module fft_bitrev_reorder #(
    parameter int FLOAT_LEN = fft_pkg::FLOAT_LEN,
    parameter int ADDR_LEN  = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*FLOAT_LEN-1:0] data_in,
    input  logic                   data_in_valid,
    output logic [2*FLOAT_LEN-1:0] data_out,
    output logic                   data_out_valid,
    output logic                   data_out_sop,
`ifdef FFT_REORDER_LAST_EN
    output logic                   data_out_last,
    output logic [15:0]            frame_cnt,
`endif
    output logic                   overflow
);

    import fft_pkg::*;

    localparam logic [0:0]          ST_IDLE  = 1'b0;
    localparam logic [0:0]          ST_RUN   = 1'b1;
    localparam logic [ADDR_LEN-1:0] LAST_IDX = '1;

    logic [ADDR_LEN-1:0]    wr_cnt;
    logic                   wr_bank;
    logic [ADDR_LEN-1:0]    rd_cnt;
    logic                   rd_bank;
    logic [0:0]             rd_state;
    logic [1:0]             bank_full;

    logic                   wr_accept;
    logic                   wr_last;
    logic [ADDR_LEN-1:0]    wr_addr_rev;
    logic                   rd_issue;
    logic                   rd_last;
    logic                   rd_first;
    logic [1:0]             set_vec;
    logic [1:0]             clr_vec;

    logic [2*FLOAT_LEN-1:0] rd_data;
    logic                   rd_valid_q;
    logic                   rd_sop_q;

    // A sample is only taken while the bank it targets is free; otherwise it is dropped.
    assign wr_accept   = data_in_valid && !bank_full[wr_bank];
    assign wr_last     = wr_accept && (wr_cnt == LAST_IDX);
    assign wr_addr_rev = ADDR_LEN'(bitrev(32'(wr_cnt), ADDR_LEN));

    // The reader starts the same cycle it finds a full bank, so IDLE costs no throughput.
    assign rd_issue = (rd_state == ST_RUN) || bank_full[rd_bank];
    assign rd_last  = rd_issue && (rd_cnt == LAST_IDX);
    assign rd_first = rd_issue && (rd_cnt == '0);

    assign set_vec = {wr_last & wr_bank, wr_last & ~wr_bank};
    assign clr_vec = {rd_last & rd_bank, rd_last & ~rd_bank};

    // Write pointer, bank toggle and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt   <= '0;
            wr_bank  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (data_in_valid && bank_full[wr_bank]) begin
                overflow <= 1'b1;
            end
            if (wr_accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == LAST_IDX) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    // Bank ownership: writer marks a bank full, reader hands it back after its last address.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full <= 2'b00;
        end else begin
            assert ((set_vec & clr_vec) == 2'b00);
            bank_full <= (bank_full | set_vec) & ~clr_vec;
        end
    end

    // Reader FSM: sequential addresses through the full bank, chaining into the other if ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= ST_IDLE;
            rd_cnt   <= '0;
            rd_bank  <= 1'b0;
        end else if (rd_issue) begin
            if (rd_cnt == LAST_IDX) begin
                rd_cnt   <= '0;
                rd_bank  <= ~rd_bank;
                rd_state <= bank_full[~rd_bank] ? ST_RUN : ST_IDLE;
            end else begin
                rd_cnt   <= rd_cnt + 1'b1;
                rd_state <= ST_RUN;
            end
        end
    end

    ram_sdp_bank #(
        .WIDTH  (2*FLOAT_LEN),
        .ADDR_W (ADDR_LEN+1)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr ({wr_bank, wr_addr_rev}),
        .wr_data (data_in),
        .rd_en   (rd_issue),
        .rd_addr ({rd_bank, rd_cnt}),
        .rd_data (rd_data)
    );

    // Sideband tracking the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_sop_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_issue;
            rd_sop_q   <= rd_first;
        end
    end

    // Output register; data is forced to zero outside valid cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            data_out_sop   <= 1'b0;
        end else begin
            data_out       <= rd_valid_q ? rd_data : '0;
            data_out_valid <= rd_valid_q;
            data_out_sop   <= rd_sop_q;
        end
    end

`ifdef FFT_REORDER_LAST_EN
    logic rd_last_q;

    // End-of-frame marker and completed-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_last_q     <= 1'b0;
            data_out_last <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            rd_last_q     <= rd_last;
            data_out_last <= rd_last_q;
            if (data_out_valid && data_out_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
